reg_file_2r1w: RTL

//   Parametrised register file: WIDTH x DEPTH storage, one masked write port, two independent

---
 rtl/reg_file_2r1w.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/reg_file_2r1w.sv
// General-purpose register file: WIDTH x DEPTH entries, one bit-masked write port and two
// independent registered read ports reporting valid and error (out of range / never written).
module reg_file_2r1w #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 16,
  parameter int               BYPASS    = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                clear,
  input  logic                                wr_en,
  input  logic [$clog2(DEPTH)-1:0]            wr_addr,
  input  logic [WIDTH-1:0]                    wr_data,
  input  logic [WIDTH-1:0]                    wr_mask,
  input  logic                                rd0_en,
  input  logic [$clog2(DEPTH)-1:0]            rd0_addr,
  output logic [WIDTH-1:0]                    rd0_data,
  output logic                                rd0_valid,
  output logic                                rd0_err,
  input  logic                                rd1_en,
  input  logic [$clog2(DEPTH)-1:0]            rd1_addr,
  output logic [WIDTH-1:0]                    rd1_data,
  output logic                                rd1_valid,
  output logic                                rd1_err
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);

  function automatic logic [WIDTH-1:0] merge_bits(input logic [WIDTH-1:0] old_val,
                                                  input logic [WIDTH-1:0] new_val,
                                                  input logic [WIDTH-1:0] mask);
    return (old_val & ~mask) | (new_val & mask);
  endfunction

  logic [WIDTH-1:0] mem_reg  [DEPTH];
  logic [WIDTH-1:0] mem_next [DEPTH];
  logic [DEPTH-1:0] written_reg;
  logic [DEPTH-1:0] written_next;
  logic [DEPTH-1:0] wr_hit;
  logic             wr_in_range;
  logic             wr_fire;

  // Clear takes priority, so a write in the same cycle never lands
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
  assign wr_fire     = wr_en && wr_in_range && !clear;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [AW-1:0] IDX = AW'(gi);
      assign wr_hit[gi]       = wr_fire && (wr_addr == IDX);
      assign mem_next[gi]     = clear      ? RESET_VAL :
                                wr_hit[gi] ? merge_bits(mem_reg[gi], wr_data, wr_mask) :
                                             mem_reg[gi];
      assign written_next[gi] = !clear && (written_reg[gi] || wr_hit[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= RESET_VAL;
      written_reg <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= mem_next[i];
      written_reg <= written_next;
    end
  end

  logic          rd_en   [2];
  logic [AW-1:0] rd_addr [2];

  assign rd_en[0]   = rd0_en;
  assign rd_en[1]   = rd1_en;
  assign rd_addr[0] = rd0_addr;
  assign rd_addr[1] = rd1_addr;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [WIDTH-1:0] old_data;
      logic             old_written;
      logic             in_range;
      logic             bypass_hit;
      logic [WIDTH-1:0] data_next;
      logic             err_next;
      logic [WIDTH-1:0] data_reg;
      logic             valid_reg;
      logic             err_reg;

      always_comb begin
        old_data    = '0;
        old_written = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
          if (rd_addr[gi] == AW'(i)) begin
            old_data    = mem_reg[i];
            old_written = written_reg[i];
          end
        end
      end

      assign in_range   = {1'b0, rd_addr[gi]} < DEPTH_W;
      assign bypass_hit = (BYPASS != 0) && wr_fire && (wr_addr == rd_addr[gi]);

      always_comb begin
        data_next = old_data;
        err_next  = !old_written;
        if (!in_range) begin
          data_next = '0;
          err_next  = 1'b1;
        end else if (bypass_hit) begin
          data_next = merge_bits(old_data, wr_data, wr_mask);
          err_next  = 1'b0;
        end
      end

      // Data and error hold their last values across idle cycles; only valid drops
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          data_reg  <= '0;
          valid_reg <= 1'b0;
          err_reg   <= 1'b0;
        end else if (rd_en[gi]) begin
          data_reg  <= data_next;
          valid_reg <= 1'b1;
          err_reg   <= err_next;
        end else begin
          valid_reg <= 1'b0;
        end
      end
    end
  endgenerate

  assign rd0_data  = g_rd[0].data_reg;
  assign rd0_valid = g_rd[0].valid_reg;
  assign rd0_err   = g_rd[0].err_reg;
  assign rd1_data  = g_rd[1].data_reg;
  assign rd1_valid = g_rd[1].valid_reg;
  assign rd1_err   = g_rd[1].err_reg;

endmodule
